// File: rtl/wallet_stats_accumulator_pkg.sv
// Shared types and default widths for the transaction-tracing pipeline
// (wallet statistics accumulator and the downstream scorer).
package wallet_stats_accumulator_pkg;

  localparam int COUNT_W_DEF = 7;
  localparam int ID_W_DEF    = 16;
  localparam int TS_W_DEF    = 10;
  localparam int VALUE_W     = 30;
  localparam int SUM_W       = 64;

  typedef enum logic [1:0] {
    METH_STANDARD = 2'b00,
    METH_TETHER   = 2'b01,
    METH_MONERO   = 2'b10,
    METH_OTHER    = 2'b11
  } method_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_PEND  = 2'b10
  } state_e;

  function automatic logic is_priv(input logic [1:0] method);
    return (method == METH_TETHER) || (method == METH_MONERO);
  endfunction

endpackage

// File: rtl/wallet_stats_outreg.sv
// Single-entry valid/ready holding register for one packed summary bundle.
// The loader must only assert load while free is high.
module wallet_stats_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wallet_stats_accumulator.sv
// Folds a contiguous-by-wallet record stream into one summary per wallet group
// and hands the summaries downstream through a single holding register.
module wallet_stats_accumulator
  import wallet_stats_accumulator_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int TS_W    = TS_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rec_valid,
  output logic               rec_ready,
  input  logic [ID_W-1:0]    rec_wallet_id,
  input  logic [TS_W-1:0]    rec_time_stamp,
  input  logic               rec_in,
  input  logic [1:0]         rec_method,
  input  logic [VALUE_W-1:0] rec_value,
  input  logic               rec_last,
  output logic               stat_valid,
  input  logic               stat_ready,
  output logic [ID_W-1:0]    stat_wallet_id,
  output logic [COUNT_W-1:0] stat_txn_count,
  output logic [COUNT_W-1:0] stat_out_count,
  output logic [COUNT_W-1:0] stat_other_count,
  output logic               stat_priv_seen,
  output logic [SUM_W-1:0]   stat_value_sum,
  output logic [TS_W-1:0]    stat_period,
  output logic               stat_truncated
);

  localparam logic [COUNT_W-1:0] CAP    = '1;
  localparam logic [COUNT_W-1:0] CAP_M1 = CAP - 1'b1;
  localparam logic [COUNT_W-1:0] ONE    = COUNT_W'(1);
  localparam int BUN_W = ID_W + 3 * COUNT_W + 1 + SUM_W + TS_W + 1;

  function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                   input logic [VALUE_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - VALUE_W){1'b0}}, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] a,
                                                 input logic en);
    if (!en || (a == CAP)) return a;
    return a + 1'b1;
  endfunction

  state_e               state_p0, state_nxt;
  logic [ID_W-1:0]      cur_id_p0;
  logic [TS_W-1:0]      first_ts_p0, last_ts_p0;
  logic [COUNT_W-1:0]   cnt_p0, out_p0, oth_p0;
  logic                 priv_p0;
  logic [SUM_W-1:0]     sum_p0;

  logic                 out_free, accept, same_id, open_new;
  logic                 close_now, trunc_now, acc_ld, emit_ld, emit_from_acc;
  logic [COUNT_W-1:0]   n_cnt, n_out, n_oth;
  logic                 n_priv, is_out, is_oth;
  logic [SUM_W-1:0]     n_sum;
  logic [TS_W-1:0]      n_first, per_acc, per_nxt;
  logic [BUN_W-1:0]     bun_acc, bun_nxt, bun_ld, stat_bus;

  assign same_id = (rec_wallet_id == cur_id_p0);

  always_comb begin
    rec_ready = 1'b0;
    if (!rst) begin
      case (state_p0)
        ST_IDLE:  rec_ready = 1'b1;
        ST_ACCUM: rec_ready = out_free || (same_id && !rec_last && (cnt_p0 < CAP_M1));
        default:  rec_ready = 1'b0;
      endcase
    end
  end

  assign accept   = rec_valid && rec_ready;
  assign open_new = (state_p0 == ST_IDLE) || !same_id;
  assign is_out   = !rec_in;
  assign is_oth   = (rec_method == METH_OTHER);

  // Group contents as they stand once the current record is folded in
  assign n_cnt   = open_new ? ONE : sat_inc(cnt_p0, 1'b1);
  assign n_out   = open_new ? {{(COUNT_W-1){1'b0}}, is_out} : sat_inc(out_p0, is_out);
  assign n_oth   = open_new ? {{(COUNT_W-1){1'b0}}, is_oth} : sat_inc(oth_p0, is_oth);
  assign n_priv  = is_priv(rec_method) || (!open_new && priv_p0);
  assign n_sum   = open_new ? {{(SUM_W - VALUE_W){1'b0}}, rec_value}
                            : sat_add_sum(sum_p0, rec_value);
  assign n_first = open_new ? rec_time_stamp : first_ts_p0;

  assign close_now = rec_last || (n_cnt == CAP);
  assign trunc_now = (n_cnt == CAP) && !rec_last;

  assign per_acc = last_ts_p0 - first_ts_p0;
  assign per_nxt = rec_time_stamp - n_first;
  assign bun_acc = {cur_id_p0, cnt_p0, out_p0, oth_p0, priv_p0, sum_p0, per_acc, 1'b0};
  assign bun_nxt = {rec_wallet_id, n_cnt, n_out, n_oth, n_priv, n_sum, per_nxt, trunc_now};
  assign bun_ld  = emit_from_acc ? bun_acc : bun_nxt;

  always_comb begin
    state_nxt     = state_p0;
    acc_ld        = 1'b0;
    emit_ld       = 1'b0;
    emit_from_acc = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        if (accept) begin
          acc_ld = 1'b1;
          if (!rec_last) begin
            state_nxt = ST_ACCUM;
          end else if (out_free) begin
            emit_ld   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_PEND;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_ld = 1'b1;
          if (!same_id) begin
            // Old group leaves now; the new one waits if it is already complete
            emit_ld       = 1'b1;
            emit_from_acc = 1'b1;
            state_nxt     = rec_last ? ST_PEND : ST_ACCUM;
          end else if (close_now) begin
            emit_ld   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_PEND: begin
        if (out_free) begin
          emit_ld       = 1'b1;
          emit_from_acc = 1'b1;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: open-group accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_IDLE;
      cur_id_p0   <= '0;
      first_ts_p0 <= '0;
      last_ts_p0  <= '0;
      cnt_p0      <= '0;
      out_p0      <= '0;
      oth_p0      <= '0;
      priv_p0     <= 1'b0;
      sum_p0      <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (acc_ld) begin
        cur_id_p0   <= rec_wallet_id;
        first_ts_p0 <= n_first;
        last_ts_p0  <= rec_time_stamp;
        cnt_p0      <= n_cnt;
        out_p0      <= n_out;
        oth_p0      <= n_oth;
        priv_p0     <= n_priv;
        sum_p0      <= n_sum;
      end
    end
  end

  // Stage p1: registered summary towards the scorer
  wallet_stats_outreg #(.W(BUN_W)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (emit_ld),
    .load_data (bun_ld),
    .ready     (stat_ready),
    .valid     (stat_valid),
    .data      (stat_bus),
    .free      (out_free)
  );

  assign {stat_wallet_id, stat_txn_count, stat_out_count, stat_other_count,
          stat_priv_seen, stat_value_sum, stat_period, stat_truncated} = stat_bus;

endmodule

// File: tb/tb_wallet_stats_accumulator.sv
// Bench for wallet_stats_accumulator: directed sequences, a cycle table for the
// handshake corners, and random traffic scored against a record-list model.
module tb_wallet_stats_accumulator;

  localparam int ID_W = 16;
  localparam int TS_W = 10;
  localparam int CW   = 7;
  localparam int CAP  = 127;

  logic            clk, rst;
  logic            rec_valid, rec_ready, rec_in, rec_last;
  logic [ID_W-1:0] rec_wallet_id;
  logic [TS_W-1:0] rec_time_stamp;
  logic [1:0]      rec_method;
  logic [29:0]     rec_value;
  logic            stat_valid, stat_ready, stat_priv_seen, stat_truncated;
  logic [ID_W-1:0] stat_wallet_id;
  logic [CW-1:0]   stat_txn_count, stat_out_count, stat_other_count;
  logic [63:0]     stat_value_sum;
  logic [TS_W-1:0] stat_period;

  wallet_stats_accumulator #(.COUNT_W(CW), .ID_W(ID_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_wallet_id(rec_wallet_id),
    .rec_time_stamp(rec_time_stamp), .rec_in(rec_in), .rec_method(rec_method),
    .rec_value(rec_value), .rec_last(rec_last),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_wallet_id(stat_wallet_id),
    .stat_txn_count(stat_txn_count), .stat_out_count(stat_out_count),
    .stat_other_count(stat_other_count), .stat_priv_seen(stat_priv_seen),
    .stat_value_sum(stat_value_sum), .stat_period(stat_period),
    .stat_truncated(stat_truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] ts;
    bit              inb;
    logic [1:0]      m;
    logic [29:0]     val;
    bit              last;
  } rec_t;

  typedef struct {
    logic [ID_W-1:0] id;
    int              txn, outc, oth;
    bit              priv;
    logic [63:0]     sum;
    logic [TS_W-1:0] per;
    bit              trunc;
  } summ_t;

  typedef struct {
    bit v; logic [ID_W-1:0] id; logic [TS_W-1:0] ts; bit inb; logic [1:0] m;
    logic [29:0] val; bit last; bit sr; bit e_rdy; bit e_sv; logic [ID_W-1:0] e_sid;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  rec_t  grp[$];
  summ_t exp_q[$];
  vec_t  tbl[14];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a group is the list of its records; the summary is read off that list
  task automatic close_group(input bit trunc);
    summ_t s;
    logic [64:0] acc;
    s.id = grp[0].id; s.txn = grp.size(); s.outc = 0; s.oth = 0; s.priv = 0;
    acc = '0;
    foreach (grp[i]) begin
      if (!grp[i].inb) s.outc++;
      if (grp[i].m == 2'b11) s.oth++;
      if (grp[i].m == 2'b01 || grp[i].m == 2'b10) s.priv = 1;
      acc = acc + 65'(grp[i].val);
      if (acc[64]) acc = {1'b0, {64{1'b1}}};
    end
    s.sum = acc[63:0];
    s.per = grp[grp.size()-1].ts - grp[0].ts;
    s.trunc = trunc;
    exp_q.push_back(s);
    grp.delete();
  endtask

  task automatic model_accept(input rec_t r);
    if (grp.size() > 0 && grp[0].id != r.id) close_group(0);
    grp.push_back(r);
    if (r.last) close_group(0);
    else if (grp.size() == CAP) close_group(1);
  endtask

  task automatic check_summary();
    summ_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL summary_unexpected: got id %0d txn %0d, expected no summary",
               stat_wallet_id, stat_txn_count);
      return;
    end
    e = exp_q.pop_front();
    if (stat_wallet_id !== e.id || int'(stat_txn_count) != e.txn ||
        int'(stat_out_count) != e.outc || int'(stat_other_count) != e.oth ||
        stat_priv_seen !== e.priv || stat_value_sum !== e.sum ||
        stat_period !== e.per || stat_truncated !== e.trunc) begin
      errors++;
      $display("FAIL summary: got id %0d txn %0d out %0d oth %0d priv %0d sum %0d per %0d tr %0d, expected id %0d txn %0d out %0d oth %0d priv %0d sum %0d per %0d tr %0d",
               stat_wallet_id, stat_txn_count, stat_out_count, stat_other_count,
               stat_priv_seen, stat_value_sum, stat_period, stat_truncated,
               e.id, e.txn, e.outc, e.oth, e.priv, e.sum, e.per, e.trunc);
    end
  endtask

  // Called at a falling edge with inputs already driven
  task automatic cycle(output bit acc);
    bit   cons;
    rec_t r;
    #1;
    acc  = rec_valid && rec_ready;
    cons = !rst && stat_valid && stat_ready;
    r = '{rec_wallet_id, rec_time_stamp, rec_in, rec_method, rec_value, rec_last};
    if (cons) check_summary();
    @(posedge clk);
    if (rst) begin
      grp.delete();
      exp_q.delete();
    end else if (acc) begin
      model_accept(r);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [ID_W-1:0] id, input logic [TS_W-1:0] ts, input bit inb,
                      input logic [1:0] m, input logic [29:0] val, input bit last);
    bit acc;
    rec_valid = 1; rec_wallet_id = id; rec_time_stamp = ts; rec_in = inb;
    rec_method = m; rec_value = val; rec_last = last;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) cycle(acc);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept for id %0d, expected accept", id);
    end
    rec_valid = 0;
  endtask

  task automatic drain();
    bit a;
    rec_valid = 0; stat_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (!stat_valid && exp_q.size() == 0) break;
      cycle(a);
    end
    chk("drain_pending", 64'(exp_q.size()), 0);
    chk("drain_stat_valid", stat_valid, 0);
  endtask

  function automatic vec_t mk(bit v, int id, int ts, bit inb, int m, int val, bit last,
                              bit sr, bit e_rdy, bit e_sv, int e_sid);
    vec_t t;
    t.v = v; t.id = ID_W'(id); t.ts = TS_W'(ts); t.inb = inb; t.m = 2'(m);
    t.val = 30'(val); t.last = last; t.sr = sr; t.e_rdy = e_rdy; t.e_sv = e_sv;
    t.e_sid = ID_W'(e_sid);
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    logic [ID_W-1:0] rid;

    tbl[0]  = mk(1, 20, 10, 0, 0, 100, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 20, 20, 1, 1, 200, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 20, 30, 0, 3, 300, 0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 21, 40, 0, 0, 400, 0, 0, 1, 0, 0);
    tbl[4]  = mk(1, 22, 50, 1, 0, 500, 0, 0, 0, 1, 20);
    tbl[5]  = mk(1, 22, 50, 1, 0, 500, 0, 0, 0, 1, 20);
    tbl[6]  = mk(1, 22, 50, 1, 0, 500, 0, 1, 1, 1, 20);
    tbl[7]  = mk(1, 23, 60, 0, 2, 600, 1, 0, 0, 1, 21);
    tbl[8]  = mk(1, 23, 60, 0, 2, 600, 1, 1, 1, 1, 21);
    tbl[9]  = mk(0,  0,  0, 0, 0,   0, 0, 0, 0, 1, 22);
    tbl[10] = mk(1, 24, 70, 0, 0, 700, 0, 0, 0, 1, 22);
    tbl[11] = mk(0,  0,  0, 0, 0,   0, 0, 1, 0, 1, 22);
    tbl[12] = mk(0,  0,  0, 0, 0,   0, 0, 1, 1, 1, 23);
    tbl[13] = mk(0,  0,  0, 0, 0,   0, 0, 1, 1, 0, 0);

    rst = 1; rec_valid = 1; rec_wallet_id = 1; rec_time_stamp = 0; rec_in = 0;
    rec_method = 0; rec_value = 0; rec_last = 0; stat_ready = 0;
    @(negedge clk);
    #1 chk("rdy_during_rst", rec_ready, 0);
    cycle(a); cycle(a);
    rst = 0; rec_valid = 0;
    #1;
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_stat_id", stat_wallet_id, 0);
    chk("rst_stat_sum", stat_value_sum, 0);
    chk("rst_idle_ready", rec_ready, 1);
    @(negedge clk);

    // Three outgoing records for id 5, then id 6 closes it
    send(5, 10, 0, 0, 1000, 0);
    send(5, 20, 0, 0, 1000, 0);
    send(5, 40, 0, 0, 1000, 0);
    send(6, 50, 0, 0, 1000, 0);
    #1;
    chk("g5_valid", stat_valid, 1);
    chk("g5_id", stat_wallet_id, 5);
    chk("g5_txn", stat_txn_count, 3);
    chk("g5_out", stat_out_count, 3);
    chk("g5_other", stat_other_count, 0);
    chk("g5_priv", stat_priv_seen, 0);
    chk("g5_sum", stat_value_sum, 3000);
    chk("g5_period", stat_period, 30);
    chk("g5_trunc", stat_truncated, 0);
    stat_ready = 1;
    send(6, 55, 1, 0, 5, 1);
    drain();

    // Single-record group with a privacy method
    send(9, 100, 1, 2, 77, 1);
    #1;
    chk("g9_valid", stat_valid, 1);
    chk("g9_id", stat_wallet_id, 9);
    chk("g9_txn", stat_txn_count, 1);
    chk("g9_priv", stat_priv_seen, 1);
    chk("g9_period", stat_period, 0);
    drain();

    // Handshake table: back-pressure on a new id, then the PEND path
    for (int i = 0; i < 14; i++) begin
      rec_valid = tbl[i].v; rec_wallet_id = tbl[i].id; rec_time_stamp = tbl[i].ts;
      rec_in = tbl[i].inb; rec_method = tbl[i].m; rec_value = tbl[i].val;
      rec_last = tbl[i].last; stat_ready = tbl[i].sr;
      #1;
      chk($sformatf("tbl%0d_rec_ready", i), rec_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_stat_valid", i), stat_valid, tbl[i].e_sv);
      if (tbl[i].e_sv) chk($sformatf("tbl%0d_stat_id", i), stat_wallet_id, tbl[i].e_sid);
      cycle(a);
    end
    drain();

    // Count cap forces a close at 127 records
    stat_ready = 1;
    for (int i = 0; i < CAP; i++) send(3, TS_W'(i), 0, 3, 1, 0);
    #1;
    chk("cap_txn", stat_txn_count, 127);
    chk("cap_other", stat_other_count, 127);
    chk("cap_trunc", stat_truncated, 1);
    send(3, 200, 1, 0, 1, 1);
    #1;
    chk("cap_next_id", stat_wallet_id, 3);
    chk("cap_next_txn", stat_txn_count, 1);
    chk("cap_next_trunc", stat_truncated, 0);
    drain();

    // Period wraps modulo 2^TS_W
    send(4, 1020, 1, 0, 10, 0);
    send(4, 5, 1, 0, 10, 1);
    #1;
    chk("wrap_period", stat_period, 9);
    chk("wrap_txn", stat_txn_count, 2);
    drain();

    for (int n = 0; n < 3000; n++) begin
      if (n == 0 || $urandom_range(0, 7) == 0) rid = ID_W'($urandom_range(1, 4));
      rec_valid      = ($urandom_range(0, 3) != 0);
      rec_wallet_id  = rid;
      rec_time_stamp = TS_W'($urandom);
      rec_in         = 1'($urandom);
      rec_method     = 2'($urandom);
      rec_value      = ($urandom_range(0, 7) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
      rec_last       = ($urandom_range(0, 15) == 0);
      stat_ready     = ($urandom_range(0, 9) < 7);
      cycle(a);
    end
    stat_ready = 1;
    send(15, 0, 0, 0, 1, 1);
    drain();

    // Reset with a held summary and an open group: neither may surface
    stat_ready = 0;
    send(11, 1, 1, 0, 10, 1);
    send(10, 2, 1, 0, 10, 0);
    send(10, 3, 1, 0, 10, 0);
    rst = 1; rec_valid = 1; rec_wallet_id = 10; rec_last = 0;
    #1 chk("rst_mid_ready", rec_ready, 0);
    cycle(a); cycle(a);
    rst = 0; rec_valid = 0;
    #1 chk("rst_mid_stat_valid", stat_valid, 0);
    stat_ready = 1;
    send(7, 9, 0, 3, 42, 1);
    #1;
    chk("post_rst_valid", stat_valid, 1);
    chk("post_rst_id", stat_wallet_id, 7);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wallet_stats_accumulator.md
Name: wallet_stats_accumulator

Overview:
- Upstream stage of the transaction-tracing scorer.
- Accepts a stream of per-transaction records, grouped contiguously by wallet id, over a valid/ready handshake.
- Accumulates per-wallet statistics: transaction count, outgoing count, other-method count, privacy-method flag, value sum, and active period.
- Emits one registered summary per wallet group over a valid/ready handshake. The downstream scorer derives its ratios and thresholds from these summaries instead of free-running counters.

Parameters:
- COUNT_W, 7, width of transaction/outgoing/method counters; a group is force-closed at 2^COUNT_W-1 records.
- ID_W, 16, wallet id width.
- TS_W, 10, timestamp width; period arithmetic is modulo 2^TS_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rec_valid  input  1  record present.
- rec_ready  output  1  record accepted when rec_valid && rec_ready.
- rec_wallet_id  input  ID_W  wallet owning the record.
- rec_time_stamp  input  TS_W  record timestamp.
- rec_in  input  1  1 = incoming, 0 = outgoing.
- rec_method  input  2  00 standard, 01 tether, 10 monero, 11 other.
- rec_value  input  30  transaction value.
- rec_last  input  1  final record of stream; flush after it.
- stat_valid  output  1  summary held.
- stat_ready  input  1  downstream consumes summary when stat_valid && stat_ready.
- stat_wallet_id  output  ID_W  wallet of summary.
- stat_txn_count  output  COUNT_W  records in group (>=1).
- stat_out_count  output  COUNT_W  records with rec_in=0.
- stat_other_count  output  COUNT_W  records with method 11.
- stat_priv_seen  output  1  any record with method 01 or 10.
- stat_value_sum  output  64  sum of rec_value, saturating at 2^64-1.
- stat_period  output  TS_W  (last_ts - first_ts) mod 2^TS_W.
- stat_truncated  output  1  group was force-closed at the count cap.

Behaviour:
- Reset (synchronous, active-high): state IDLE; stat_valid=0; all stat_* outputs=0; accumulators cleared. rec_ready=0 while rst=1. rst mid-group discards the partial group and any held summary.
- States:
  - IDLE: no open group.
  - ACCUM: group open.
  - PEND: a single-record group is pending emission behind a held summary.
- Output-register-free condition: out_free = !stat_valid || stat_ready.
- rec_ready:
  - IDLE: 1.
  - ACCUM: 1 if the record will not close a group; otherwise out_free. Combinationally, rec_ready = out_free || (rec_wallet_id == cur_id && !rec_last && count < cap-1).
  - PEND: 0.
- Accept in IDLE: open group. Set cur_id, first_ts = last_ts = ts, count=1, out=!rec_in, other=(method==11), priv=(method 01/10), sum=value. If rec_last, close immediately (emit); go to IDLE.
- Accept in ACCUM, same id: increment counters (saturating at cap), set last_ts = ts, add value. Close the group if rec_last, or if count reaches cap = 2^COUNT_W-1 (stat_truncated=1 on cap close only). After close, go to IDLE.
- Accept in ACCUM, different id: emit the old group and open a new group from this record in the same cycle. If the record also has rec_last, go to PEND.
- PEND: when out_free, emit the single-record group and go to IDLE.
- Emission: summary registers load on the accepting clock edge. stat_valid rises on the next cycle (latency 1 cycle from closing record to stat_valid).
- Summary fields stay stable while stat_valid && !stat_ready.
- stat_valid clears on consume unless a new emission occurs in the same cycle; a same-cycle emission keeps it at 1 with new data.
- Period: computed as a TS_W-bit unsigned subtraction, so wrap-around is natural. Example: first=1020, last=5 gives 9.
- Timestamps are not checked for monotonicity.

Decomposition:
- Shared package (e.g. tracing_pkg):
  - method encodings STANDARD/TETHER/MONERO/OTHER.
  - state enum IDLE/ACCUM/PEND.
  - default widths COUNT_W=7, TS_W=10, VALUE_W=30, SUM_W=64, shared with the scorer.
- One natural sub-module: wallet_stats_outreg, the single-entry valid/ready holding register for the summary bundle.

Test Plan:
- Records for id 5 with ts 10, 20, 40, all in=0, method 00, value 1000 each, then id 6 ts 50 -> on the cycle after id 6 is accepted: stat_valid=1, id=5, txn=3, out=3, other=0, priv=0, sum=3000, period=30; the id 6 group is open.
- Single record id 9, method 10, rec_last=1, stat_ready=1 -> one summary: txn=1, priv=1, period=0; state IDLE.
- stat_ready=0 with summary held; a new-id record arrives -> rec_ready=0 and the summary is stable. stat_ready=1 -> record accepted and the next summary follows with no loss.
- 127 records for id 3, method 11 -> force close: txn=127, other=127, truncated=1. The 128th record with id 3 opens a new group with txn=1.
- id 4 first_ts=1020, last_ts=5, then rec_last -> period=9.
- Boundary record with rec_last while stat_ready=0 -> old summary emitted, state PEND with rec_ready=0. After two consumes, two summaries are received in order.
- Reset mid-group, then new id 7 record -> the discarded group is never emitted; the first summary is id 7.
